// File: rtl/uart_tx.sv
// uart_tx -- UART transmitter for the hx8k_breakout UART path.
//
// Serialises one word per frame onto uart0_txd: start bit (0), data bits
// LSB first, an optional parity bit, then one or two stop bits (1). Words
// are taken over a valid/ready handshake. A new frame only starts while the
// synchronised CTS# input is low. A frame that has started always completes.
//
// Ports
//   clk        in   board clock
//   resetn     in   asynchronous active-low reset
//   tx_data    in   word to send, captured on the accepting edge
//   tx_valid   in   tx_data is valid
//   tx_ready   out  a word presented now would be accepted at the next edge
//   tx_busy    out  a frame is in progress (registered)
//   uart0_cts  in   CTS#, asynchronous, active-low (0 = peer may receive)
//   uart0_txd  out  serial line, idle high (registered)

module uart_tx #(
  parameter int CLK_FREQ_HZ     = 12_000_000,
  parameter int BAUD_RATE_BPS   = 9600,
  parameter int BAUD_RATE_COUNT = CLK_FREQ_HZ / BAUD_RATE_BPS,
  parameter int UART_DATA_BITS  = 8,
  parameter int PARITY_BITS     = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1,
  parameter int SYNC_STAGES     = 3
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      tx_busy,
  input  logic                      uart0_cts,
  output logic                      uart0_txd
);

  localparam int CNT_W = $clog2(BAUD_RATE_COUNT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BAUD_RATE_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(UART_DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit that makes the total count of ones even (or odd when PARITY_ODD).
  function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t                    state_r, state_nxt_s;
  logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]          idx_r, idx_nxt_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_nxt_s;
  logic                      parity_r, parity_nxt_s;
  logic                      txd_r, txd_nxt_s;
  logic                      busy_r, busy_nxt_s;
  logic [SYNC_STAGES-1:0]    cts_sync_r;

  logic cts_ok_s;
  logic baud_tick_s;
  logic ready_s;
  logic accept_s;

  // CTS# synchroniser; resets to "blocked" so no frame starts until low CTS# has crossed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cts_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      cts_sync_r <= {cts_sync_r[SYNC_STAGES-2:0], uart0_cts};
    end
  end

  assign cts_ok_s    = (cts_sync_r[SYNC_STAGES-1] == 1'b0);
  assign baud_tick_s = (cnt_r == CNT_MAX);
  // Ready in IDLE, or in the very last cycle of the last stop bit so the next
  // start bit follows with no idle gap.
  assign ready_s     = cts_ok_s &&
                       ((state_r == S_IDLE) ||
                        ((state_r == S_STOP) && (idx_r == STOP_LAST) && baud_tick_s));
  assign accept_s    = tx_valid && ready_s;

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    idx_nxt_s    = idx_r;
    shift_nxt_s  = shift_r;
    parity_nxt_s = parity_r;
    txd_nxt_s    = txd_r;
    busy_nxt_s   = busy_r;

    // The bit timer runs only inside a frame and wraps at the end of each bit.
    if (state_r == S_IDLE) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (baud_tick_s) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end

    case (state_r)
      S_IDLE: begin
        idx_nxt_s  = IDX_ZERO;
        txd_nxt_s  = 1'b1;
        busy_nxt_s = 1'b0;
      end
      S_START: begin
        if (baud_tick_s) begin
          state_nxt_s = S_DATA;
          idx_nxt_s   = IDX_ZERO;
          txd_nxt_s   = shift_r[0];
        end else begin
          state_nxt_s = S_START;
        end
      end
      S_DATA: begin
        if (baud_tick_s) begin
          if (idx_r == DATA_LAST) begin
            idx_nxt_s = IDX_ZERO;
            if (PARITY_BITS != 0) begin
              state_nxt_s = S_PARITY;
              txd_nxt_s   = parity_r;
            end else begin
              state_nxt_s = S_STOP;
              txd_nxt_s   = 1'b1;
            end
          end else begin
            // Data leaves LSB first; the shifter keeps the next bit at index 1.
            idx_nxt_s   = idx_r + IDX_ONE;
            shift_nxt_s = shift_r >> 1;
            txd_nxt_s   = shift_r[1];
          end
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (baud_tick_s) begin
          state_nxt_s = S_STOP;
          idx_nxt_s   = IDX_ZERO;
          txd_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (baud_tick_s) begin
          if (idx_r == STOP_LAST) begin
            state_nxt_s = S_IDLE;
            idx_nxt_s   = IDX_ZERO;
            txd_nxt_s   = 1'b1;
            busy_nxt_s  = 1'b0;
          end else begin
            idx_nxt_s = idx_r + IDX_ONE;
          end
        end else begin
          state_nxt_s = S_STOP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = CNT_ZERO;
        idx_nxt_s   = IDX_ZERO;
        txd_nxt_s   = 1'b1;
        busy_nxt_s  = 1'b0;
      end
    endcase

    // An accept can only happen in IDLE or at the end of the final stop bit;
    // it overrides whatever those states decided and drives the start bit
    // on the accepting edge itself.
    if (accept_s) begin
      state_nxt_s  = S_START;
      cnt_nxt_s    = CNT_ZERO;
      idx_nxt_s    = IDX_ZERO;
      shift_nxt_s  = tx_data;
      parity_nxt_s = calc_parity(tx_data);
      txd_nxt_s    = 1'b0;
      busy_nxt_s   = 1'b1;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Sequencer state, bit timer, shifter and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r  <= S_IDLE;
      cnt_r    <= CNT_ZERO;
      idx_r    <= IDX_ZERO;
      shift_r  <= {UART_DATA_BITS{1'b0}};
      parity_r <= 1'b0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      idx_r    <= idx_nxt_s;
      shift_r  <= shift_nxt_s;
      parity_r <= parity_nxt_s;
      txd_r    <= txd_nxt_s;
      busy_r   <= busy_nxt_s;
    end
  end

  assign tx_ready  = ready_s;
  assign tx_busy   = busy_r;
  assign uart0_txd = txd_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- scoreboard bench for uart_tx.
//
// Three transmitters share clock, reset and CTS#, all at 4 clocks per bit:
//   dut 0: 8 data, no parity, 1 stop   (frame 10 bits, 40 cycles)
//   dut 1: 8 data, even parity, 1 stop (frame 11 bits, 44 cycles)
//   dut 2: 8 data, odd parity, 2 stop  (frame 12 bits, 48 cycles)
// Drivers push the expected line waveform of each accepted word into a
// per-dut queue; one monitor per dut pops it when a start bit appears and
// checks every cycle of the frame, plus busy/ready, and idle behaviour.

module tb_uart_tx;

  localparam int BAUD = 4;
  localparam int SYNC = 3;

  typedef struct packed {
    logic [15:0] bits;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       cts;
  logic [2:0] valid;
  logic [7:0] din [3];
  logic [2:0] ready;
  logic [2:0] busy;
  logic [2:0] txd;

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [SYNC-1:0] cts_hist;
  logic            cts_ok_m;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CTS# value as it was SYNC clock edges ago; reset means "blocked".
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cts_hist <= {SYNC{1'b1}};
    else         cts_hist <= {cts_hist[SYNC-2:0], cts};
  end
  assign cts_ok_m = ~cts_hist[SYNC-1];

  uart_tx #(.BAUD_RATE_COUNT(BAUD), .UART_DATA_BITS(8), .PARITY_BITS(0),
            .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u0 (
    .clk(clk), .resetn(resetn), .tx_data(din[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_busy(busy[0]), .uart0_cts(cts), .uart0_txd(txd[0]));

  uart_tx #(.BAUD_RATE_COUNT(BAUD), .UART_DATA_BITS(8), .PARITY_BITS(1),
            .PARITY_ODD(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u1 (
    .clk(clk), .resetn(resetn), .tx_data(din[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_busy(busy[1]), .uart0_cts(cts), .uart0_txd(txd[1]));

  uart_tx #(.BAUD_RATE_COUNT(BAUD), .UART_DATA_BITS(8), .PARITY_BITS(1),
            .PARITY_ODD(1), .STOP_BITS(2), .SYNC_STAGES(SYNC)) u2 (
    .clk(clk), .resetn(resetn), .tx_data(din[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_busy(busy[2]), .uart0_cts(cts), .uart0_txd(txd[2]));

  function automatic int par_en(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic int stops(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return 1 + 8 + par_en(k) + stops(k);
  endfunction

  // Line level for each bit time of a frame carrying d (bit 0 = start bit).
  function automatic logic [15:0] ref_frame(input int k, input logic [7:0] d);
    logic [15:0] b;
    logic        p;
    b = 16'hFFFF;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    if (par_en(k) != 0) begin
      // Even parity: total ones including the parity bit is even.
      p = (($countones(d) % 2) == 1) ? 1'b1 : 1'b0;
      if (k == 2) p = ~p;
      b[9] = p;
    end
    return b;
  endfunction

  task automatic push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Present d on dut k until accepted; called and returns at a falling edge.
  task automatic send(input int k, input logic [7:0] d, output int unsigned acc);
    exp_t e;
    bit   done;
    done = 1'b0;
    acc = 0;
    valid[k] = 1'b1;
    din[k] = d;
    for (int t = 0; t < 2000 && !done; t++) begin
      #1;
      if (ready[k] === 1'b1) begin
        acc = cyc + 1;
        e.bits = ref_frame(k, d);
        e.cyc = acc;
        push(k, e);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout dut%0d: word %h not accepted in 2000 cycles (required accept)", k, d);
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (busy === 3'b000 && q0.size() == 0 && q1.size() == 0 && q2.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_idle: busy=%b queued=%0d/%0d/%0d after 400 cycles (required all idle)",
               busy, q0.size(), q1.size(), q2.size());
    end
  endtask

  // Walk one frame on dut k starting from the sample where its start bit was seen.
  task automatic check_frame(input int k);
    exp_t e;
    bit   ok;
    int   fs;
    int   bad_bit, bad_busy, bad_rdy;
    logic got_bit, got_busy, got_rdy, want_bit, want_rdy;
    pop(k, e, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL unexpected_start dut%0d: txd=0 at cycle %0d with no accepted word (required txd=1)", k, cyc);
      return;
    end
    if (cyc != e.cyc) begin
      errors++;
      $display("FAIL start_latency dut%0d: start bit seen at cycle %0d, required %0d", k, cyc, e.cyc);
    end
    fs = frame_len(k);
    bad_bit = -1; bad_busy = -1; bad_rdy = -1;
    got_bit = 1'b0; got_busy = 1'b0; got_rdy = 1'b0; want_bit = 1'b0; want_rdy = 1'b0;
    for (int t = 0; t < fs * BAUD; t++) begin
      if (t != 0) @(negedge clk);
      if (resetn !== 1'b1) return;
      if (txd[k] !== e.bits[t / BAUD] && bad_bit < 0) begin
        bad_bit = t; got_bit = txd[k]; want_bit = e.bits[t / BAUD];
      end
      if (busy[k] !== 1'b1 && bad_busy < 0) begin
        bad_busy = t; got_busy = busy[k];
      end
      if (ready[k] !== (cts_ok_m && (t == fs * BAUD - 1)) && bad_rdy < 0) begin
        bad_rdy = t; got_rdy = ready[k]; want_rdy = cts_ok_m && (t == fs * BAUD - 1);
      end
    end
    checks += 3;
    if (bad_bit >= 0) begin
      errors++;
      $display("FAIL frame_bits dut%0d word %h: txd=%b at frame cycle %0d, required %b (expected line %b)",
               k, e.bits[8:1], got_bit, bad_bit, want_bit, e.bits);
    end
    if (bad_busy >= 0) begin
      errors++;
      $display("FAIL frame_busy dut%0d: tx_busy=%b at frame cycle %0d, required 1", k, got_busy, bad_busy);
    end
    if (bad_rdy >= 0) begin
      errors++;
      $display("FAIL frame_ready dut%0d: tx_ready=%b at frame cycle %0d, required %b", k, got_rdy, bad_rdy, want_rdy);
    end
  endtask

  task automatic monitor(input int k);
    forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
        if (txd[k] === 1'b0) begin
          check_frame(k);
        end else begin
          checks++;
          if (txd[k] !== 1'b1 || busy[k] !== 1'b0 || ready[k] !== cts_ok_m) begin
            errors++;
            $display("FAIL idle dut%0d cycle %0d: txd=%b busy=%b ready=%b, required txd=1 busy=0 ready=%b",
                     k, cyc, txd[k], busy[k], ready[k], cts_ok_m);
          end
        end
      end
    end
  endtask

  task automatic drive_random(input int k);
    int unsigned a;
    for (int n = 0; n < 12; n++) begin
      send(k, 8'($urandom), a);
      if ($urandom_range(0, 2) != 0) begin
        valid[k] = 1'b0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
      end
    end
    valid[k] = 1'b0;
  endtask

  task automatic cts_wiggle();
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) cts = ~cts;
    end
    cts = 1'b0;
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none
  end

  initial begin
    int unsigned a1, a2, mark;
    resetn = 1'b0;
    cts = 1'b1;
    valid = 3'b000;
    for (int k = 0; k < 3; k++) din[k] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (txd[k] !== 1'b1 || busy[k] !== 1'b0 || ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: txd=%b busy=%b ready=%b, required 1 0 0", k, txd[k], busy[k], ready[k]);
      end
    end
    resetn = 1'b1;

    // CTS# high: word offered but never taken.
    @(negedge clk);
    valid[0] = 1'b1;
    din[0] = 8'h5A;
    repeat (6) begin
      @(negedge clk);
      #1;
      checks++;
      if (ready[0] !== 1'b0 || txd[0] !== 1'b1) begin
        errors++;
        $display("FAIL cts_block: ready=%b txd=%b while CTS# high, required 0 1", ready[0], txd[0]);
      end
    end

    // Drop CTS#: accept lands on the edge after SYNC cycles of synchronisation.
    mark = cyc;
    cts = 1'b0;
    send(0, 8'h55, a1);
    valid[0] = 1'b0;
    checks++;
    if (a1 != mark + SYNC + 1) begin
      errors++;
      $display("FAIL cts_release_latency: accept at cycle %0d, required %0d", a1, mark + SYNC + 1);
    end
    // Raise CTS# mid-frame; the frame must still complete.
    repeat (10) @(negedge clk);
    cts = 1'b1;
    wait_idle();
    cts = 1'b0;
    repeat (5) @(negedge clk);

    // Back-to-back words: second start exactly one frame after the first.
    send(0, 8'hA5, a1);
    send(0, 8'h3C, a2);
    valid[0] = 1'b0;
    checks++;
    if (a2 - a1 != 32'd40) begin
      errors++;
      $display("FAIL back_to_back: accepts %0d cycles apart, required 40", a2 - a1);
    end
    wait_idle();

    // Parity (even on dut 1, odd on dut 2) and two stop bits.
    fork
      begin send(1, 8'h07, a1); valid[1] = 1'b0; end
      begin send(2, 8'h07, a2); valid[2] = 1'b0; end
    join
    wait_idle();
    send(2, 8'hFF, a1);
    valid[2] = 1'b0;
    wait_idle();

    // Reset during data bit 3, then a clean frame afterwards.
    send(0, 8'hC3, a1);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    #1;
    resetn = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (txd[k] !== 1'b1 || busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_midframe dut%0d: txd=%b busy=%b, required 1 0", k, txd[k], busy[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    mark = cyc;
    resetn = 1'b1;
    @(negedge clk);
    send(0, 8'h81, a1);
    valid[0] = 1'b0;
    checks++;
    if (a1 != mark + SYNC + 1) begin
      errors++;
      $display("FAIL post_reset_latency: accept at cycle %0d, required %0d", a1, mark + SYNC + 1);
    end
    wait_idle();

    // Random words, gaps and CTS# activity on all three transmitters.
    fork
      drive_random(0);
      drive_random(1);
      drive_random(2);
      cts_wiggle();
    join
    cts = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
